// File: rtl/aes_round_scheduler.sv
// Sequencing controller that shares one iterative AES round datapath between
// an encrypt and a decrypt requester. Arbitration is round-robin and every control output is registered.
module aes_round_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_req,
  input  logic [7:0] enc_param,
  input  logic       dec_req,
  input  logic [7:0] dec_param,
  input  logic       out_ready,
  output logic       enc_grant,
  output logic       dec_grant,
  output logic       err,
  output logic       load,
  output logic       round_en,
  output logic       last_round,
  output logic       dir,
  output logic [3:0] nr,
  output logic [3:0] rk_idx,
  output logic       busy,
  output logic       out_valid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ROUND  = 3'd2,
    S_HOLD   = 3'd3,
    S_REJECT = 3'd4
  } state_t;

  // Key length in bytes to round count; 0 marks an illegal length.
  function automatic logic [3:0] decode_nr(input logic [7:0] p);
    case (p)
      8'd16:   decode_nr = 4'd10;
      8'd24:   decode_nr = 4'd12;
      8'd32:   decode_nr = 4'd14;
      default: decode_nr = 4'd0;
    endcase
  endfunction

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic       r_last_dec, w_last_dec_nxt;
  logic       r_dir, w_dir_nxt;
  logic [3:0] r_nr, w_nr_nxt;
  logic [3:0] r_rk, w_rk_nxt;
  logic       r_enc_grant, w_enc_grant_nxt;
  logic       r_dec_grant, w_dec_grant_nxt;
  logic       r_err, w_err_nxt;
  logic       r_load, w_load_nxt;
  logic       r_round_en, w_round_en_nxt;
  logic       r_last_round, w_last_round_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_out_valid, w_out_valid_nxt;
  logic       w_sel_dec;
  logic [3:0] w_sel_nr;

  // Next state and next-cycle output values; outputs are registered below.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_dec_nxt   = r_last_dec;
    w_dir_nxt        = r_dir;
    w_nr_nxt         = r_nr;
    w_rk_nxt         = 4'd0;
    w_enc_grant_nxt  = 1'b0;
    w_dec_grant_nxt  = 1'b0;
    w_err_nxt        = 1'b0;
    w_load_nxt       = 1'b0;
    w_round_en_nxt   = 1'b0;
    w_last_round_nxt = 1'b0;
    w_busy_nxt       = 1'b0;
    w_out_valid_nxt  = 1'b0;
    w_cnt_inc        = r_cnt + 4'd1;
    // Tie goes to whichever side was not served last.
    w_sel_dec        = dec_req & (~enc_req | ~r_last_dec);
    w_sel_nr         = decode_nr(w_sel_dec ? dec_param : enc_param);
    case (r_state)
      S_IDLE: begin
        if (enc_req | dec_req) begin
          w_last_dec_nxt  = w_sel_dec;
          w_enc_grant_nxt = ~w_sel_dec;
          w_dec_grant_nxt = w_sel_dec;
          if (w_sel_nr != 4'd0) begin
            w_state_nxt = S_LOAD;
            w_dir_nxt   = w_sel_dec;
            w_nr_nxt    = w_sel_nr;
            w_cnt_nxt   = 4'd0;
            w_load_nxt  = 1'b1;
            w_busy_nxt  = 1'b1;
            w_rk_nxt    = w_sel_dec ? w_sel_nr : 4'd0;
          end else begin
            w_state_nxt = S_REJECT;
            w_err_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD, S_ROUND: begin
        w_busy_nxt = 1'b1;
        if ((r_state == S_ROUND) && (r_cnt == r_nr)) begin
          w_state_nxt     = S_HOLD;
          w_out_valid_nxt = 1'b1;
        end else begin
          w_state_nxt      = S_ROUND;
          w_cnt_nxt        = w_cnt_inc;
          w_round_en_nxt   = 1'b1;
          w_last_round_nxt = (w_cnt_inc == r_nr);
          w_rk_nxt         = r_dir ? (r_nr - w_cnt_inc) : w_cnt_inc;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_out_valid_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
        end
      end
      S_REJECT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter, arbitration history and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_dec   <= 1'b1;
      r_dir        <= 1'b0;
      r_nr         <= 4'd0;
      r_rk         <= 4'd0;
      r_enc_grant  <= 1'b0;
      r_dec_grant  <= 1'b0;
      r_err        <= 1'b0;
      r_load       <= 1'b0;
      r_round_en   <= 1'b0;
      r_last_round <= 1'b0;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_dec   <= w_last_dec_nxt;
      r_dir        <= w_dir_nxt;
      r_nr         <= w_nr_nxt;
      r_rk         <= w_rk_nxt;
      r_enc_grant  <= w_enc_grant_nxt;
      r_dec_grant  <= w_dec_grant_nxt;
      r_err        <= w_err_nxt;
      r_load       <= w_load_nxt;
      r_round_en   <= w_round_en_nxt;
      r_last_round <= w_last_round_nxt;
      r_busy       <= w_busy_nxt;
      r_out_valid  <= w_out_valid_nxt;
    end
  end

  assign enc_grant  = r_enc_grant;
  assign dec_grant  = r_dec_grant;
  assign err        = r_err;
  assign load       = r_load;
  assign round_en   = r_round_en;
  assign last_round = r_last_round;
  assign dir        = r_dir;
  assign nr         = r_nr;
  assign rk_idx     = r_rk;
  assign busy       = r_busy;
  assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed bench for aes_round_scheduler: a block-schedule model is compared every cycle,
// and hand-computed latencies and sequences pin that model.
module tb_aes_round_scheduler;

  logic       clk;
  logic       reset;
  logic       enc_req, dec_req, out_ready;
  logic [7:0] enc_param, dec_param;
  logic       enc_grant, dec_grant, err, load, round_en, last_round, dir, busy, out_valid;
  logic [3:0] nr, rk_idx;

  aes_round_scheduler dut (
    .clk(clk), .reset(reset),
    .enc_req(enc_req), .enc_param(enc_param),
    .dec_req(dec_req), .dec_param(dec_param),
    .out_ready(out_ready),
    .enc_grant(enc_grant), .dec_grant(dec_grant), .err(err),
    .load(load), .round_en(round_en), .last_round(last_round),
    .dir(dir), .nr(nr), .rk_idx(rk_idx), .busy(busy), .out_valid(out_valid)
  );

  typedef struct packed {
    logic       ge, gd, err, load, ren, last, ov, busy, dir;
    logic [3:0] nr, rk;
  } exp_t;

  exp_t cur;
  exp_t sched[$];
  bit   last_dec;
  int   n_chk = 0;
  int   n_err = 0;
  int   rk_log[$];
  int   grant_n, n_last, lat;
  int   exp_enc16[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
  int   exp_dec32[15] = '{14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nr_of(input logic [7:0] p);
    case (p)
      8'd16:   return 10;
      8'd24:   return 12;
      8'd32:   return 14;
      default: return 0;
    endcase
  endfunction

  // Block-level model: an accepted request expands into a whole schedule of future cycles.
  task automatic model_step();
    exp_t nx, e;
    bit   sd;
    int   n;
    nx = '0;
    if (cur.ov && !out_ready) begin
      nx = cur;
    end else if (sched.size() > 0) begin
      nx = sched.pop_front();
    end else if (!cur.ov && !cur.err && (enc_req || dec_req)) begin
      sd = dec_req && (!enc_req || !last_dec);
      n = nr_of(sd ? dec_param : enc_param);
      last_dec = sd;
      nx.ge = !sd;
      nx.gd = sd;
      if (n == 0) begin
        nx.err = 1'b1;
      end else begin
        nx.load = 1'b1; nx.busy = 1'b1; nx.dir = sd; nx.nr = 4'(n);
        nx.rk = sd ? 4'(n) : 4'd0;
        for (int i = 1; i <= n; i++) begin
          e = '0; e.ren = 1'b1; e.busy = 1'b1; e.dir = sd; e.nr = 4'(n);
          e.rk = sd ? 4'(n - i) : 4'(i);
          e.last = (i == n);
          sched.push_back(e);
        end
        e = '0; e.ov = 1'b1; e.busy = 1'b1; e.dir = sd; e.nr = 4'(n);
        sched.push_back(e);
      end
    end
    cur = nx;
  endtask

  initial begin
    cur = '0;
    last_dec = 1'b1;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        cur = '0;
        sched.delete();
        last_dec = 1'b1;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("enc_grant", 32'(enc_grant), 32'(cur.ge));
      chk("dec_grant", 32'(dec_grant), 32'(cur.gd));
      chk("err", 32'(err), 32'(cur.err));
      chk("load", 32'(load), 32'(cur.load));
      chk("round_en", 32'(round_en), 32'(cur.ren));
      chk("last_round", 32'(last_round), 32'(cur.last));
      chk("out_valid", 32'(out_valid), 32'(cur.ov));
      chk("busy", 32'(busy), 32'(cur.busy));
      if (cur.busy) begin
        chk("dir", 32'(dir), 32'(cur.dir));
        chk("nr", 32'(nr), 32'(cur.nr));
      end
      if (cur.load || cur.ren) chk("rk_idx", 32'(rk_idx), 32'(cur.rk));
    end
  end

  task automatic wait_valid(output int l);
    l = -1; grant_n = -1; n_last = 0;
    rk_log.delete();
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (enc_grant) begin enc_req = 1'b0; if (grant_n < 0) grant_n = n; end
      if (dec_grant) begin dec_req = 1'b0; if (grant_n < 0) grant_n = n; end
      if (load || round_en) rk_log.push_back(int'(rk_idx));
      if (last_round) n_last++;
      if (out_valid) begin l = n; break; end
    end
    if (l < 0) chk("timeout_out_valid", 32'd0, 32'd1);
  endtask

  initial begin
    bit [3:0] ord;
    int       ng, prev, found;
    int       gap[3];
    reset = 1'b1; enc_req = 1'b0; dec_req = 1'b0; out_ready = 1'b1;
    enc_param = 8'd0; dec_param = 8'd0;
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_nr", 32'(nr), 32'd0);
    chk("rst_rk_idx", 32'(rk_idx), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;

    // Encrypt, 16-byte key.
    @(negedge clk);
    enc_req = 1'b1; enc_param = 8'd16;
    wait_valid(lat);
    chk("enc16_grant_cycle", 32'(grant_n), 32'd1);
    chk("enc16_valid_cycle", 32'(lat), 32'd12);
    chk("enc16_last_count", 32'(n_last), 32'd1);
    chk("enc16_dir", 32'(dir), 32'd0);
    chk("enc16_rk_len", 32'(rk_log.size()), 32'd11);
    if (rk_log.size() == 11) begin
      chk("enc16_rk_load", 32'(rk_log[0]), 32'd0);
      for (int i = 0; i < 10; i++) chk("enc16_rk_seq", 32'(rk_log[i + 1]), 32'(exp_enc16[i]));
    end
    @(negedge clk);
    chk("enc16_one_valid", 32'(out_valid), 32'd0);

    // Decrypt, 32-byte key.
    dec_req = 1'b1; dec_param = 8'd32;
    wait_valid(lat);
    chk("dec32_valid_cycle", 32'(lat), 32'd16);
    chk("dec32_dir", 32'(dir), 32'd1);
    chk("dec32_rk_len", 32'(rk_log.size()), 32'd15);
    if (rk_log.size() == 15)
      for (int i = 0; i < 15; i++) chk("dec32_rk_seq", 32'(rk_log[i]), 32'(exp_dec32[i]));
    @(negedge clk);

    // Both requesters held with 24-byte keys.
    enc_param = 8'd24; dec_param = 8'd24; enc_req = 1'b1; dec_req = 1'b1;
    ng = 0; prev = -1; ord = 4'd0;
    for (int n = 1; n <= 100 && ng < 4; n++) begin
      @(negedge clk);
      if (enc_grant || dec_grant) begin
        ord[ng] = dec_grant;
        if (prev >= 0) gap[ng - 1] = n - prev;
        prev = n;
        ng++;
      end
    end
    enc_req = 1'b0; dec_req = 1'b0;
    chk("rr_grant_count", 32'(ng), 32'd4);
    chk("rr_grant_order", 32'(ord), 32'b1010);
    if (ng == 4) for (int i = 0; i < 3; i++) chk("rr_grant_spacing", 32'(gap[i]), 32'd15);
    wait_valid(lat);
    @(negedge clk);

    // Illegal key length, then a normal decrypt.
    enc_req = 1'b1; enc_param = 8'd20;
    found = 0;
    for (int n = 1; n <= 5 && found == 0; n++) begin
      @(negedge clk);
      if (enc_grant) begin
        found = 1;
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_load", 32'(load), 32'd0);
        chk("rej_busy", 32'(busy), 32'd0);
      end
    end
    if (found == 0) chk("timeout_reject_grant", 32'd0, 32'd1);
    enc_req = 1'b0;
    @(negedge clk);
    chk("rej_idle_busy", 32'(busy), 32'd0);
    dec_req = 1'b1; dec_param = 8'd16;
    wait_valid(lat);
    chk("after_rej_grant_cycle", 32'(grant_n), 32'd1);
    chk("after_rej_valid_cycle", 32'(lat), 32'd12);
    @(negedge clk);

    // Consumer stalls while a decrypt request waits.
    out_ready = 1'b0;
    enc_req = 1'b1; enc_param = 8'd16;
    wait_valid(lat);
    chk("stall_valid_cycle", 32'(lat), 32'd12);
    dec_req = 1'b1; dec_param = 8'd16;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_hold_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_dir", 32'(dir), 32'd0);
      chk("stall_hold_nr", 32'(nr), 32'd10);
      chk("stall_no_grant", 32'(dec_grant), 32'd0);
    end
    out_ready = 1'b1;
    wait_valid(lat);
    chk("stall_dec_grant_cycle", 32'(grant_n), 32'd2);
    chk("stall_dec_valid_cycle", 32'(lat), 32'd13);
    @(negedge clk);

    // Reset during encrypt round 5.
    enc_req = 1'b1; enc_param = 8'd16;
    found = 0;
    for (int n = 1; n <= 20 && found == 0; n++) begin
      @(negedge clk);
      if (enc_grant) enc_req = 1'b0;
      if (round_en && rk_idx == 4'd5) found = 1;
    end
    if (found == 0) chk("timeout_round5", 32'd0, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_round_en", 32'(round_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rk_idx", 32'(rk_idx), 32'd0);
    chk("arst_nr", 32'(nr), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("arst_no_valid", 32'(out_valid), 32'd0);
    end
    enc_req = 1'b1; dec_req = 1'b1; enc_param = 8'd16; dec_param = 8'd16;
    wait_valid(lat);
    chk("arst_tie_enc_first", 32'(dir), 32'd0);
    chk("arst_tie_valid_cycle", 32'(lat), 32'd12);
    wait_valid(lat);
    chk("arst_second_dec", 32'(dir), 32'd1);
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_round_scheduler.md
# aes_round_scheduler

Sequencing controller that time-shares one iterative AES round datapath between an encrypt requester and a decrypt requester. It arbitrates round-robin and decodes the key-length byte (16/24/32) into the round count Nr. It then drives the datapath's load, round-enable, first/last-round and round-key-index controls, and holds the result under a valid/ready handshake. It replaces the fully unrolled per-key-size cipher instances behind the SPI slave front end with a single shared engine.

## Interface
- No parameters; datapath width fixed at 128 bits, round counter 4 bits.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low; `reset`=0 forces reset state immediately.
- `enc_req` in 1: encrypt request; held high until `enc_grant`.
- `enc_param` in 8: key length in bytes for encrypt request (16, 24, 32).
- `dec_req` in 1: decrypt request; held high until `dec_grant`.
- `dec_param` in 8: key length in bytes for decrypt request.
- `enc_grant` / `dec_grant` out 1 each: one-cycle acknowledge; requester may drop request/data after it.
- `err` out 1: one-cycle pulse, granted request rejected for illegal param.
- `load` out 1: datapath captures block and key, performs initial AddRoundKey.
- `round_en` out 1: datapath executes one round this cycle.
- `last_round` out 1: current round omits (Inv)MixColumns.
- `dir` out 1: 0 = encrypt, 1 = decrypt; valid whenever `busy`.
- `nr` out 4: decoded round count (10/12/14), stable while `busy`.
- `rk_idx` out 4: round-key index used this cycle.
- `busy` out 1: high from LOAD through HOLD.
- `out_valid` out 1: datapath result valid.
- `out_ready` in 1: consumer accepts result.

## Operation
- States: IDLE, LOAD, ROUND, HOLD, REJECT.
- Param decode: 16→10, 24→12, 32→14; any other value is illegal.
- IDLE: if no request, stay.
  - One request: select it.
  - Both requests: select the one not served last. `last_served` resets to decrypt, so encrypt wins the first tie.
  - Selected legal: latch `dir` and `nr`, update `last_served`, go to LOAD.
  - Selected illegal: go to REJECT. `last_served` is still updated.
- LOAD (1 cycle): `load`=1 and the matching grant=1.
  - Encrypt: `rk_idx`=0.
  - Decrypt: `rk_idx`=`nr`.
  - Round counter r set to 1. Next state ROUND.
- ROUND (`nr` cycles): `round_en`=1.
  - Encrypt: `rk_idx`=r.
  - Decrypt: `rk_idx`=`nr`−r.
  - `last_round`=1 when r==`nr`, then go to HOLD. Otherwise r←r+1.
- HOLD: `out_valid`=1 until `out_ready`=1 is sampled, then go to IDLE.
  - Requests are not arbitrated in HOLD.
  - `out_ready` while `out_valid`=0 is ignored.
- REJECT (1 cycle): matching grant=1 and `err`=1; no `load`/`round_en`. Next state IDLE.
- Requests arriving while not in IDLE wait; the arbiter samples only in IDLE.
- `rk_idx` arithmetic is 4-bit unsigned and never wraps (range 0..14).

## Timing
- Reset values: all outputs 0 (`nr`=0, `rk_idx`=0, `dir`=0), state IDLE, r=0, `last_served`=decrypt.
- Reset mid-operation aborts immediately. No `out_valid` is produced for the aborted block.
- Request sampled in IDLE at edge k:
  - LOAD during cycle k+1.
  - Rounds during cycles k+2 .. k+1+Nr.
  - `out_valid` from cycle k+2+Nr.
  - So Nr=10 → 12 cycles, 12 → 14, 14 → 16.
- Back-to-back: `out_ready` accepted at edge m → IDLE in cycle m+1 → next LOAD at m+2 at the earliest. There is one mandatory bubble.
- Exactly one of `load`, `round_en`, `out_valid`, `err` is high per cycle, or none.
- Grant is high in exactly one cycle per accepted or rejected request.
- `busy`=0 only in IDLE and REJECT.

## Test plan
- Encrypt only, param 16, `out_ready` tied high:
  - `enc_grant`+`load` one cycle after sampling.
  - 10 `round_en` cycles with `rk_idx` 1..10, `last_round` only on the 10th.
  - `out_valid` at cycle 12 for one cycle, `dir`=0.
- Decrypt, param 32:
  - `rk_idx` 14 at LOAD, then 13..0 across 14 rounds.
  - `out_valid` at cycle 16, `dir`=1.
- `enc_req` and `dec_req` both held high continuously with param 24, `out_ready` high:
  - Grant order enc, dec, enc, dec.
  - Each block 12 rounds, with one idle bubble between HOLD and the next LOAD.
- `enc_param`=20:
  - `enc_grant`+`err` in the same single cycle.
  - No `load`; `busy` stays 0; back to IDLE.
  - A following `dec_req` is served normally.
- `out_ready` held low 5 cycles after `out_valid`:
  - `out_valid`, `dir`, and `nr` hold.
  - A pending `dec_req` is not granted until the cycle after acceptance plus one.
- `reset` low for one cycle during round 5:
  - All outputs 0 asynchronously and no `out_valid`.
  - After release, a new `enc_req` wins the arbitration tie against `dec_req`.
